// File: rtl/cursor_paint_exec.sv
// cursor_paint_exec: executes keyboard instruction nibbles. It latches a paint colour
// and issues a one-cycle write strobe at the cursor cell. It also moves the cursor
// over an H_CELLS x V_CELLS grid with wrap-around.
// Optional feature: define CURSOR_AUTO_REPEAT_EN to enable hold-to-repeat stepping
// (REPEAT_DELAY before the first repeat, then one step every REPEAT_PERIOD cycles).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   func_index[1:0]       0 = paint, 1 = move, 2/3 = idle
//   func1_instruction[3:0] {R, G, B, set}
//   func2_instruction[3:0] {East, West, North, South}
//   soft_reset            keyboard-side reset request (async level)
//   cursor_x, cursor_y    cursor cell
//   paint_color[2:0]      last latched {R,G,B}
//   paint_we              one-cycle write strobe at (cursor_x, cursor_y)
//   cursor_step           one-cycle pulse on every cursor move
module cursor_paint_exec #(
    parameter int unsigned H_CELLS       = 80,
    parameter int unsigned V_CELLS       = 60,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   func_index,
    input  logic [3:0]                   func1_instruction,
    input  logic [3:0]                   func2_instruction,
    input  logic                         soft_reset,
    output logic [$clog2(H_CELLS)-1:0]   cursor_x,
    output logic [$clog2(V_CELLS)-1:0]   cursor_y,
    output logic [2:0]                   paint_color,
    output logic                         paint_we,
    output logic                         cursor_step
);

    localparam int unsigned XW = $clog2(H_CELLS);
    localparam int unsigned YW = $clog2(V_CELLS);
    localparam int unsigned SW = 11;

    // Elaboration-time sanity check of the configuration
    if (H_CELLS < 2 || V_CELLS < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("cursor_paint_exec: all size/timing parameters must be >= 2");
    end

    // Two-flop synchroniser for every non-clock input; vld_q marks when sync2 holds real data
    logic [SW-1:0] sync1_q, sync2_q;
    logic [1:0]    vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vld_q   <= '0;
        end else begin
            sync1_q <= {soft_reset, func2_instruction, func1_instruction, func_index};
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

    logic [1:0] fidx_s;
    logic [3:0] f1_s, f2_s;
    logic       srst_s;

    assign fidx_s = sync2_q[1:0];
    assign f1_s   = sync2_q[5:2];
    assign f2_s   = sync2_q[9:6];
    assign srst_s = sync2_q[10];

    // Function gating: only the selected function sees its instruction nibble
    logic [3:0] fn1, dir;
    assign fn1 = (fidx_s == 2'd0) ? f1_s : 4'b0;
    assign dir = (fidx_s == 2'd1) ? f2_s : 4'b0;

    // Edge history: a press only counts once a released (0) value has been observed.
    // Cleared by either reset, so a button held across reset must be released first.
    logic set_arm_q, dir_arm_q;
    logic set_ev, dir_ev;

    assign set_ev = set_arm_q & fn1[0];
    assign dir_ev = dir_arm_q & (|dir);

    // Opposing bits cancel; remaining bits give the step direction
    logic e_mv, w_mv, n_mv, s_mv, moving;
    assign e_mv   = dir[3] & ~dir[2];
    assign w_mv   = dir[2] & ~dir[3];
    assign n_mv   = dir[1] & ~dir[0];
    assign s_mv   = dir[0] & ~dir[1];
    assign moving = e_mv | w_mv | n_mv | s_mv;

    logic step;

`ifdef CURSOR_AUTO_REPEAT_EN
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Repeat FSM state and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold-to-repeat sequencing; direction changes while held do not restart timing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dir_ev) begin
                    step    = 1'b1;
                    cnt_d   = CNT_W'(REPEAT_DELAY - 1);
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (dir == 4'b0) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    step    = 1'b1;
                    cnt_d   = CNT_W'(REPEAT_PERIOD - 1);
                    state_d = S_REPEAT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_REPEAT: begin
                if (dir == 4'b0) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    step  = 1'b1;
                    cnt_d = CNT_W'(REPEAT_PERIOD - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (srst_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            step    = 1'b0;
        end
    end
`else
    // One step per fresh press; soft reset suppresses it
    assign step = dir_ev & ~srst_s;
`endif

    // Wrap-around next position
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    always_comb begin
        x_nxt = cursor_x;
        y_nxt = cursor_y;
        if (e_mv) begin
            x_nxt = (cursor_x == XW'(H_CELLS - 1)) ? '0 : cursor_x + XW'(1);
        end else if (w_mv) begin
            x_nxt = (cursor_x == '0) ? XW'(H_CELLS - 1) : cursor_x - XW'(1);
        end
        if (s_mv) begin
            y_nxt = (cursor_y == YW'(V_CELLS - 1)) ? '0 : cursor_y + YW'(1);
        end else if (n_mv) begin
            y_nxt = (cursor_y == '0) ? YW'(V_CELLS - 1) : cursor_y - YW'(1);
        end
    end

    // Execute stage: registered outputs and edge history; soft reset wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_x    <= '0;
            cursor_y    <= '0;
            paint_color <= '0;
            paint_we    <= 1'b0;
            cursor_step <= 1'b0;
            set_arm_q   <= 1'b0;
            dir_arm_q   <= 1'b0;
        end else if (srst_s) begin
            cursor_x    <= '0;
            cursor_y    <= '0;
            paint_color <= '0;
            paint_we    <= 1'b0;
            cursor_step <= 1'b0;
            set_arm_q   <= 1'b0;
            dir_arm_q   <= 1'b0;
        end else begin
            paint_we    <= set_ev;
            if (set_ev) begin
                paint_color <= fn1[3:1];
            end
            cursor_step <= step & moving;
            if (step) begin
                cursor_x <= x_nxt;
                cursor_y <= y_nxt;
            end
            set_arm_q <= vld_q[1] & ~fn1[0];
            dir_arm_q <= vld_q[1] & ~(|dir);
        end
    end

endmodule

// File: tb/tb_cursor_paint_exec.sv
// Scoreboard bench for cursor_paint_exec on a 7x5 grid with REPEAT_DELAY=10, REPEAT_PERIOD=4.
// Stimulus pushes expected events (kind, cycle, colour/position); a negedge monitor pops them.
module tb_cursor_paint_exec;

    localparam int unsigned H  = 7;
    localparam int unsigned V  = 5;
`ifdef CURSOR_AUTO_REPEAT_EN
    localparam int XR = 6;
`else
    localparam int XR = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] func_index;
    logic [3:0] func1_instruction;
    logic [3:0] func2_instruction;
    logic       soft_reset;
    logic [2:0] cursor_x;
    logic [2:0] cursor_y;
    logic [2:0] paint_color;
    logic       paint_we;
    logic       cursor_step;

    cursor_paint_exec #(
        .H_CELLS      (H),
        .V_CELLS      (V),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .func_index       (func_index),
        .func1_instruction(func1_instruction),
        .func2_instruction(func2_instruction),
        .soft_reset       (soft_reset),
        .cursor_x         (cursor_x),
        .cursor_y         (cursor_y),
        .paint_color      (paint_color),
        .paint_we         (paint_we),
        .cursor_step      (cursor_step)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_paint;
        int         at;
        logic [2:0] col;
        int         x;
        int         y;
    } ev_t;

    ev_t q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_paint(input int at, input logic [2:0] c);
        q.push_back('{is_paint: 1'b1, at: at, col: c, x: 0, y: 0});
    endtask

    task automatic exp_step(input int at, input int x, input int y);
        q.push_back('{is_paint: 1'b0, at: at, col: 3'b0, x: x, y: y});
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output event must match the head of the scoreboard
    ev_t e;
    always @(negedge clk) begin
        if (paint_we) begin
            if (q.size() == 0) chk("unexpected_paint", cyc, -1);
            else begin
                e = q.pop_front();
                chk("paint_kind", 1, int'(e.is_paint));
                chk("paint_cycle", cyc, e.at);
                chk("paint_color", int'(paint_color), int'(e.col));
            end
        end
        if (cursor_step) begin
            if (q.size() == 0) chk("unexpected_step", cyc, -1);
            else begin
                e = q.pop_front();
                chk("step_kind", 0, int'(e.is_paint));
                chk("step_cycle", cyc, e.at);
                chk("step_x", int'(cursor_x), e.x);
                chk("step_y", int'(cursor_y), e.y);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        func_index = 2'd2;
        func1_instruction = 4'b0;
        func2_instruction = 4'b0;
        soft_reset = 1'b0;
        go(3);
        chk("rst_x", int'(cursor_x), 0);
        chk("rst_y", int'(cursor_y), 0);
        chk("rst_color", int'(paint_color), 0);
        chk("rst_pulses", int'({paint_we, cursor_step}), 0);
        rst_n = 1'b1;
        go(100);
        chk("idle_x", int'(cursor_x), 0);
        chk("idle_y", int'(cursor_y), 0);
        chk("idle_color", int'(paint_color), 0);

        // Paint: held set gives a single write
        func_index = 2'd0;
        func1_instruction = 4'b1011;
        exp_paint(cyc + 3, 3'b101);
        go(50);
        func1_instruction = 4'b0;
        go(5);
        chk("color_held", int'(paint_color), 5);
        func1_instruction = 4'b0111;
        exp_paint(cyc + 3, 3'b011);
        go(4);
        func1_instruction = 4'b0;
        go(6);

        // Wrap: West and North from origin, then East across the right edge
        func_index = 2'd1;
        go(4);
        func2_instruction = 4'b0100; exp_step(cyc + 3, 6, 0); go(3);
        func2_instruction = 4'b0;    go(5);
        func2_instruction = 4'b0010; exp_step(cyc + 3, 6, 4); go(3);
        func2_instruction = 4'b0;    go(5);
        func2_instruction = 4'b1000; exp_step(cyc + 3, 0, 4); go(3);
        func2_instruction = 4'b0;    go(5);

        // Hold East 30 cycles
        func2_instruction = 4'b1000;
        exp_step(cyc + 3, 1, 4);
`ifdef CURSOR_AUTO_REPEAT_EN
        exp_step(cyc + 13, 2, 4);
        exp_step(cyc + 17, 3, 4);
        exp_step(cyc + 21, 4, 4);
        exp_step(cyc + 25, 5, 4);
        exp_step(cyc + 29, 6, 4);
`endif
        go(30);
        func2_instruction = 4'b0;
        go(8);
        chk("repeat_x", int'(cursor_x), XR);

        // Gating: move nibble ignored while idle; E+W cancels; N+E is one diagonal step
        func_index = 2'd2;
        func2_instruction = 4'b1111; go(10);
        func2_instruction = 4'b0;    go(3);
        func_index = 2'd1;           go(3);
        func2_instruction = 4'b1100; go(5);
        func2_instruction = 4'b0;    go(5);
        chk("cancel_x", int'(cursor_x), XR);
        func2_instruction = 4'b1010;
        exp_step(cyc + 3, (XR + 1) % 7, 3);
        go(3);
        func2_instruction = 4'b0;
        go(5);

        // Soft reset while South is held: no step after release until re-pressed
        func2_instruction = 4'b0001;
        exp_step(cyc + 3, (XR + 1) % 7, 4);
        go(6);
        soft_reset = 1'b1; go(5);
        soft_reset = 1'b0; go(40);
        chk("srst_x", int'(cursor_x), 0);
        chk("srst_y", int'(cursor_y), 0);
        func2_instruction = 4'b0;    go(5);
        func2_instruction = 4'b0001; exp_step(cyc + 3, 0, 1); go(3);
        func2_instruction = 4'b0;    go(5);

        // Paint then rst_n mid-hold of South: same re-press rule
        func_index = 2'd0;
        func1_instruction = 4'b1111; exp_paint(cyc + 3, 3'b111); go(4);
        func1_instruction = 4'b0;    go(4);
        func_index = 2'd1;           go(4);
        func2_instruction = 4'b0001;
        exp_step(cyc + 3, 0, 2);
        go(6);
        rst_n = 1'b0; go(3);
        rst_n = 1'b1; go(40);
        chk("rstn_x", int'(cursor_x), 0);
        chk("rstn_y", int'(cursor_y), 0);
        chk("rstn_color", int'(paint_color), 0);
        func2_instruction = 4'b0;    go(5);
        func2_instruction = 4'b0001; exp_step(cyc + 3, 0, 1); go(3);
        func2_instruction = 4'b0;    go(10);

        chk("pending_events", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
